// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-aware round-robin arbiter for the async FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int IDW   = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    output logic                  pkt_done
);

    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_LOCK  = 1'b1;
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           pkt_done_q, pkt_done_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW:0]   cand;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_valid;
    logic           gnt_last;
    logic           sel_valid;
    logic [DSIZE-1:0] sel_data;
    logic           accept;

    // Round-robin scan starting at rr_ptr; one extra bit keeps the wrap compare exact for any NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && req_valid[i] && (cand == (IDW+1)'(i))) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_idx   = (state_q == ST_LOCK) ? lock_id_q : win_idx;
        sel_valid = 1'b0;
        gnt_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_valid = req_valid[i];
                gnt_last  = req_last[i];
                sel_data  = req_data[i*DSIZE +: DSIZE];
            end
        end
        gnt_valid = (state_q == ST_LOCK) ? sel_valid : win_found;
    end

    // Reset also gates the grant so nothing is written while the arbiter is held in reset.
    assign accept = gnt_valid & ~wfull & wrst_n;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (gnt_idx == IDW'(i));
        end
    end

    assign winc  = accept;
    assign wdata = sel_data;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_id_d  = lock_id_q;
        pkt_done_d = accept & gnt_last;
        if (accept) begin
            owner_d = gnt_idx;
            if (gnt_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDW'(1);
            end else begin
                state_d   = ST_LOCK;
                lock_id_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_id_q  <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_id_q  <= lock_id_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign owner    = owner_q;
    assign busy     = (state_q == ST_LOCK);
    assign pkt_done = pkt_done_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single write port of the async FIFO (winc/wdata/wfull) among NREQ requesters in the write clock domain.
- Each requester uses a valid/ready handshake and marks the final word of a packet with last.
- Once a packet starts, its grant is held until the last word is accepted, so packets never interleave in the FIFO.
- Sits directly in front of the FIFO write side; wfull is consumed combinationally so the FIFO can never overflow.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DSIZE, 8, data word width; must match the FIFO data width.
- IDW, 2, owner index width; must satisfy 2^IDW >= NREQ.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester word valid.
- req_last  input  NREQ  per-requester last-word-of-packet marker; qualified by req_valid.
- req_data  input  NREQ*DSIZE  packed data; requester i uses bits [i*DSIZE +: DSIZE].
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- wfull  input  1  FIFO full flag, write domain.
- winc  output  1  FIFO write enable.
- wdata  output  DSIZE  FIFO write data.
- owner  output  IDW  index of the most recently granted requester (registered).
- busy  output  1  high while a multi-word packet holds the lock.
- pkt_done  output  1  one-cycle registered pulse after any last word is accepted.

Behaviour:
- Reset (async, wrst_n=0):
  - state=IDLE, rr_ptr=0, owner=0, busy=0, pkt_done=0.
  - Combinational outputs follow from this state: winc=0 and req_ready=0 whenever wfull=1 or no valid is pending.
- States are IDLE and LOCK, one register bit; busy = (state==LOCK).
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - If a winner exists and wfull=0: req_ready[winner]=1, winc=1, wdata=req_data[winner], owner<=winner.
  - If the accepted word has last=1: stay IDLE, rr_ptr<=(winner+1) mod NREQ, pkt_done<=1.
  - If the accepted word has last=0: state<=LOCK, lock_id<=winner, rr_ptr unchanged.
- LOCK:
  - Only lock_id may be granted: req_ready[lock_id] = req_valid[lock_id] & ~wfull; winc equals the same term.
  - wdata = req_data[lock_id].
  - On acceptance with last=1: state<=IDLE, rr_ptr<=(lock_id+1) mod NREQ, pkt_done<=1.
  - If the owner deasserts valid, hold LOCK indefinitely (no timeout). Other requesters see ready=0.
- Handshake rules:
  - A word transfers in a cycle iff req_valid[i] & req_ready[i]. winc is high exactly in those cycles.
  - req_ready never depends on the requester's own ready, and may depend combinationally on req_valid and wfull.
  - Requesters must hold data, last and valid stable until accepted.
- wfull=1:
  - winc=0 and all req_ready=0.
  - state, rr_ptr and owner are unchanged; no arbitration decision is committed.
  - wdata is don't-care.
- pkt_done: high exactly one cycle after each accepted last word, otherwise 0. Back-to-back single-word packets produce a continuous high.
- Wrap-around: rr_ptr is computed mod NREQ. For non-power-of-two NREQ, indices >= NREQ are never produced.
- Throughput: one word per cycle when the granted requester is valid and wfull=0. There is no bubble between packets from different requesters.
- Reset mid-packet: the lock is dropped immediately and the packet is truncated in the FIFO. Recovery is the requester's responsibility.
- RTL requirements:
  - All state in wclk flops with async clear.
  - No combinational path from winc back to wfull.

Test Plan:
1. Assert wrst_n=0 with all four req_valid=1 -> winc=0, req_ready=0000, busy=0, owner=0, pkt_done=0 while in reset.
2. All four requesters continuously valid with last=1, data 0x10/0x21/0x32/0x43, wfull=0 -> wdata sequence 0x10,0x21,0x32,0x43,0x10, one word per cycle; pkt_done high from the second cycle on.
3. Req1 sends 3-word packet 0xA1,0xA2,0xA3 (last on 0xA3) while req0 and req2 hold single words -> wdata 0xA1,0xA2,0xA3 contiguous; busy=1 for two cycles; req0/req2 ready=0 throughout; pkt_done pulses after 0xA3; next grant goes to req2, then req0.
4. wfull=1 for 2 cycles in the middle of req1's packet -> winc=0 and req_ready=0000 for those cycles; FIFO receives 0xA1,0xA2,0xA3 exactly once each, in order; rr_ptr and owner unchanged across the stall.
5. In LOCK with owner req3, req3 drops valid for 3 cycles while req0 is valid -> winc=0 and req0 not granted; packet resumes from req3 when it reasserts valid.
6. Pulse wrst_n=0 for one cycle during LOCK on req2 -> busy=0 asynchronously; after release, with req0 and req2 valid the first grant goes to req0 (rr_ptr=0).
